// File: rtl/dac_ctrl_pkg.sv
// Shared constants and state type for the DAC waveform sequencer.
package dac_ctrl_pkg;

    localparam int DATA_W    = 14;
    localparam int ADDR_W    = 5;
    localparam int TABLE_LEN = 20;
    localparam int DIV_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [DATA_W-1:0] MIDSCALE     = 14'h2000;
    localparam logic [7:0]        AMP_UNITY    = 8'd128;
    localparam int                AMP_SHIFT    = 7;
    localparam int                DRAIN_CYCLES = 2;

endpackage

// File: rtl/dac_amp_scale.sv
// Output stage: offset removal, gain multiply, arithmetic shift, optional dither LSB
// and saturation into a registered DAC word with a one-cycle valid.
module dac_amp_scale
    import dac_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vld_i,
    input  logic              clear_i,
    input  logic              dith_i,
    input  logic [7:0]        amp_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    localparam int PW = DATA_W + 10;
    localparam int RW = PW + 1;
    localparam logic [DATA_W-1:0] MAX_CODE = '1;

    logic signed [DATA_W:0] s_w;
    logic signed [PW-1:0]   s_x;
    logic signed [PW-1:0]   a_x;
    logic signed [PW-1:0]   p_w;
    logic signed [RW-1:0]   r_w;
    logic [DATA_W-1:0]      sat_w;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   valid_q;

    always_comb begin
        s_w = $signed({1'b0, data_i}) - $signed({1'b0, MIDSCALE});
        s_x = $signed({{(PW-DATA_W-1){s_w[DATA_W]}}, s_w});
        a_x = $signed({{(PW-8){1'b0}}, amp_i});
        p_w = s_x * a_x;
        // Floor division by the unity gain keeps amp=128 bit-exact.
        r_w = ($signed({p_w[PW-1], p_w}) >>> AMP_SHIFT)
            + $signed({{(RW-DATA_W){1'b0}}, MIDSCALE})
            + $signed({{(RW-1){1'b0}}, dith_i});
        if (r_w[RW-1])
            sat_w = '0;
        else if (|r_w[RW-2:DATA_W])
            sat_w = MAX_CODE;
        else
            sat_w = r_w[DATA_W-1:0];

        data_d = data_q;
        if (clear_i)
            data_d = MIDSCALE;
        else if (vld_i)
            data_d = sat_w;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= MIDSCALE;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= vld_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/dac_wave_ctrl.sv
// Sine-table playback sequencer: sample-rate divider, phase stepping, period counting.
// Define DAC_WAVE_CTRL_DITHER_EN to add a 16-bit LFSR dither bit to each sample.
//
// state | meaning
// IDLE  | accepting config, waiting for start
// RUN   | divider ticking, launching table reads
// DRAIN | letting in-flight samples reach the DAC, then done
module dac_wave_ctrl
    import dac_ctrl_pkg::*;
(
    input  logic              ref_clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_step,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [15:0]       cfg_cycles,
    input  logic [7:0]        cfg_amp,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0]   LEN_W      = TABLE_LEN[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LEN_A      = TABLE_LEN[ADDR_W-1:0];
    localparam int                DRAIN_LD   = DRAIN_CYCLES - 1;
    localparam logic [1:0]        DRAIN_LOAD = DRAIN_LD[1:0];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [15:0]       wrap_q, wrap_d;
    logic [1:0]        drain_q, drain_d;
    logic              launch_q, launch_d;
    logic              launch2_q;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] step_q;
    logic [DIV_W-1:0]  divcfg_q;
    logic [15:0]       cycles_q;
    logic [7:0]        amp_q;

    logic [ADDR_W:0]   sum_w, diff_w;
    logic [ADDR_W-1:0] next_w;
    logic              wrap_w, last_w, cfg_load_w, clear_w, dith_w;

    always_comb begin
        sum_w      = {1'b0, addr_q} + {1'b0, step_q};
        diff_w     = sum_w - LEN_W;
        wrap_w     = (sum_w >= LEN_W);
        next_w     = wrap_w ? diff_w[ADDR_W-1:0] : sum_w[ADDR_W-1:0];
        last_w     = wrap_w && (cycles_q != 16'd0) && ((wrap_q + 16'd1) == cycles_q);
        cfg_load_w = cfg_valid && (state_q == IDLE);

        state_d  = state_q;
        addr_d   = addr_q;
        div_d    = div_q;
        wrap_d   = wrap_q;
        drain_d  = drain_q;
        launch_d = 1'b0;
        done_d   = 1'b0;
        clear_w  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = RUN;
                    addr_d   = '0;
                    div_d    = '0;
                    wrap_d   = '0;
                    launch_d = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (div_q == divcfg_q) begin
                    div_d = '0;
                    if (last_w) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        addr_d   = next_w;
                        launch_d = 1'b1;
                        if (wrap_w && (cycles_q != 16'd0))
                            wrap_d = wrap_q + 16'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    clear_w = 1'b1;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            div_q     <= '0;
            wrap_q    <= '0;
            drain_q   <= '0;
            launch_q  <= 1'b0;
            launch2_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            div_q     <= div_d;
            wrap_q    <= wrap_d;
            drain_q   <= drain_d;
            launch_q  <= launch_d;
            launch2_q <= launch_q;
            done_q    <= done_d;
        end
    end

    // Out-of-range steps would walk the address past the table; treat them like 0.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            step_q   <= ADDR_W'(1);
            divcfg_q <= '0;
            cycles_q <= '0;
            amp_q    <= AMP_UNITY;
        end else if (cfg_load_w) begin
            step_q   <= ((cfg_step == '0) || (cfg_step >= LEN_A)) ? ADDR_W'(1) : cfg_step;
            divcfg_q <= cfg_div;
            cycles_q <= cfg_cycles;
            amp_q    <= cfg_amp;
        end
    end

`ifdef DAC_WAVE_CTRL_DITHER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset)
            lfsr_q <= 16'hACE1;
        else if (launch_d)
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
    end

    assign dith_w = lfsr_q[0];
`else
    assign dith_w = 1'b0;
`endif

    dac_amp_scale u_scale (
        .clk_i   (ref_clk),
        .rst_i   (reset),
        .vld_i   (launch2_q),
        .clear_i (clear_w),
        .dith_i  (dith_w),
        .amp_i   (amp_q),
        .data_i  (tbl_data),
        .data_o  (dac_data),
        .valid_o (dac_valid)
    );

    assign tbl_addr  = addr_q;
    assign busy      = (state_q != IDLE);
    assign cfg_ready = (state_q == IDLE);
    assign done      = done_q;

endmodule

// File: doc/dac_wave_ctrl.md
Name: dac_wave_ctrl

Overview:
Sequencer for the 14-bit DAC waveform path. It generates read addresses into the sine lookup table (20 entries, 1-cycle read latency) at a programmable sample rate and phase step. It applies amplitude scaling with saturation and drives dac_data. It runs a programmable number of table periods, or runs continuously, under a config/start/stop handshake from the control plane.

Parameters:
DATA_W, 14, DAC sample width (offset binary)
ADDR_W, 5, table address width
TABLE_LEN, 20, number of table entries
DIV_W, 8, sample-rate divider width

Ports:
ref_clk  in  1  sole clock (10 MHz)
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  config write strobe
cfg_ready  out  1  high only in IDLE
cfg_step  in  ADDR_W  phase step per sample; must be < TABLE_LEN; 0 treated as 1
cfg_div  in  DIV_W  sample period = cfg_div+1 ref_clk cycles
cfg_cycles  in  16  table periods to play; 0 = continuous
cfg_amp  in  8  gain, 128 = unity
start  in  1  begin playback (IDLE only)
stop  in  1  abort playback
tbl_addr  out  ADDR_W  table read address
tbl_data  in  DATA_W  table word for tbl_addr of previous cycle
dac_data  out  DATA_W  scaled sample to DAC
dac_valid  out  1  1-cycle pulse per new dac_data
busy  out  1  high when not IDLE
done  out  1  1-cycle pulse on return to IDLE

Behaviour:
- Reset values (async, immediate): state=IDLE; tbl_addr=0; dac_data=MIDSCALE (0x2000); dac_valid=0; done=0; busy=0; cfg_ready=1.
- Config registers reset to: step=1, div=0, cycles=0, amp=128.
- Config: cfg_valid && cfg_ready latches all cfg_* fields. cfg_valid outside IDLE is ignored.
- FSM states: IDLE, RUN, DRAIN.
- IDLE->RUN on start.
  - If start and cfg_valid arrive in the same cycle, the new config is used.
  - If start and stop arrive in the same cycle, start is ignored.
  - Entering RUN: tbl_addr=0, divider=0, wrap count=0, and a sample is launched.
- RUN:
  - The divider counts 0..div. Tick when divider==div, then the divider reloads 0. With div=0, a tick occurs every cycle.
  - On tick: next = tbl_addr+step. If next>=TABLE_LEN, next -= TABLE_LEN and this is a wrap. tbl_addr=next and a sample is launched.
  - If the wrap brings the wrap count to cycles (cycles!=0): tbl_addr is not updated, no sample is launched, and the FSM goes to DRAIN.
  - stop in RUN: go to DRAIN next edge; no further launches.
- DRAIN: lasts exactly 2 cycles so in-flight samples complete, then IDLE with a done pulse on the IDLE-entry cycle. dac_data is then set to MIDSCALE. dac_valid is not asserted for this return.
- Sample pipeline: each launch edge L delivers dac_data/dac_valid at edge L+2 (ROM at L+1, scale register at L+2).
- Scaling:
  - s = tbl_data - 2^(DATA_W-1), signed DATA_W+1 bits.
  - p = s*amp, signed.
  - r = (p >>> 7) + MIDSCALE.
  - Saturate r to [0, 2^DATA_W-1].
  - amp=128 is bit-exact pass-through; amp=0 gives MIDSCALE.
- Wrap-around: the address is always in [0, TABLE_LEN-1]. The wrap counter is 16 bits and never increments in continuous mode.

Optional Feature:
DAC_WAVE_CTRL_DITHER_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,15,13,4; seed 0xACE1 on reset) advances on each launch. Its LSB is added to r before saturation.
- Undefined: no LFSR and no dither; output exactly as specified above.

Decomposition:
- Package dac_ctrl_pkg holds:
  - state enum {IDLE, RUN, DRAIN}
  - MIDSCALE
  - AMP_UNITY=128
  - AMP_SHIFT=7
  - DRAIN_CYCLES=2
- Sub-module dac_amp_scale is natural: a registered stage doing offset removal, multiply, shift, optional dither add and saturation, producing dac_data and dac_valid.

Test Plan:
- Reset asserted mid-RUN (async, between edges) -> dac_data=0x2000, tbl_addr=0, busy=0 immediately; cfg_ready=1.
- step=1, div=0, cycles=1, amp=128, identity-ROM model -> exactly 20 dac_valid pulses. Data equals table[0..19] in order, first pulse 2 edges after start. Then DRAIN and a done pulse.
- step=3, div=4, cycles=0 -> addresses 0,3,...,18,1,4,... every 5 cycles. Wrap is correct; done never pulses. stop -> dac_valid stops within 2 cycles; done after DRAIN.
- amp=0 -> all samples 0x2000.
- amp=255 with table word 0x3FFF -> 0x3FFF; word 0x0000 -> 0x0000 (saturation both rails).
- cfg_valid during RUN with new amp -> ignored (output unchanged). start+stop same cycle in IDLE -> stays IDLE, busy=0.
